au8_op_sequencer: RTL and testbench
===================================

// Module: au8_op_sequencer
// PURPOSE
// - Front-end controller that drives the AU8 arithmetic unit's load and clear interface from a single Enter button.
// - Debounces Enter and sequences operand A, operand B and the result/condition-code latch.
// - Emits clean one-pulse InA/InB/Out/Clear strobes and a stable operand bus X.
// - Replaces hand-pressed pushbuttons on the AU8 control inputs; sits between board switches/keys and AU8.
// PARAMETERS
// - DEBOUNCE_CYCLES  default 16'd50000  consecutive stable samples before a button level is accepted (>=1)
// - SETTLE_CYCLES    default 4'd4       cycles held in EXEC between InB strobe and Out latch (>=1)
// - CNT_W            default 16         width of debounce counter; must hold DEBOUNCE_CYCLES
// PORTS
// - CLK           in   1  system clock; all state on rising edge
// - CLR           in   1  asynchronous active-low reset
// - SW            in   8  operand switches
// - AS_SW         in   1  add(0)/subtract(1) switch
// - Enter         in   1  raw Enter button, active-high, asynchronous to CLK
// - ClearReq      in   1  raw clear button, active-high, asynchronous to CLK
// - Chain         in   1  chain-result request (used only with AU8_CHAIN_EN)
// - Rout          in   8  AU8 registered result (used only with AU8_CHAIN_EN)
// - X             out  8  operand bus to AU8
// - InA, InB, Out out  1  one-cycle load strobes to AU8 registers A, B, R/CC
// - Clear         out  1  one-cycle clear strobe to AU8
// - Add_Subtract  out  1  registered operation select to AU8
// - Busy          out  1  high in LOAD_A, LOAD_B, EXEC, LATCH
// - Phase         out  3  state code: WAIT_A=0 LOAD_A=1 WAIT_B=2 LOAD_B=3 EXEC=4 LATCH=5 SHOW=6
// BEHAVIOUR
// - Reset (CLR=0, async): state WAIT_A; X=0; InA=InB=Out=Clear=0; Add_Subtract=0; Busy=0; Phase=0; all counters and synchronizers cleared.
// - Button conditioning (Enter, ClearReq)
//   - 2-FF synchronizer per button, then a debounce counter.
//   - The debounced level changes only after DEBOUNCE_CYCLES equal consecutive synchronized samples; any mismatch reloads the counter.
//   - enter_p / clear_p: one-cycle pulse on the debounced 0->1 edge. Releases produce no pulse.
// - FSM (one transition per cycle)
//   - WAIT_A: enter_p -> LOAD_A.
//   - LOAD_A: exactly 3 cycles.
//     - Cycle 0: X <= SW.
//     - Cycle 1: InA=1.
//     - Cycle 2: InA=0, X held.
//     - Then -> WAIT_B.
//   - WAIT_B: enter_p -> LOAD_B; Add_Subtract <= AS_SW on that same edge.
//   - LOAD_B: as LOAD_A, using InB. Then -> EXEC.
//   - EXEC: SETTLE_CYCLES cycles; X and Add_Subtract held. Then -> LATCH.
//   - LATCH: 3 cycles; Out=1 in the middle cycle only. Then -> SHOW.
//   - SHOW: enter_p -> WAIT_A (result stays displayed downstream).
// - Latency: enter_p in WAIT_B at cycle t gives InB high at t+2 and Out high at t+SETTLE_CYCLES+5.
// - X, Add_Subtract: change only on the edges listed above; never during any strobe-high cycle or the cycle adjacent to it.
// - Enter in any Busy state: dropped, not queued.
// - ClearReq
//   - clear_p in any state: Clear=1 for the next cycle; state <= WAIT_A; X=0; Add_Subtract=0.
//   - Any strobe in flight is cancelled; a strobe that would rise on that cycle stays low.
// - Same-cycle enter_p and clear_p: clear wins; enter_p is discarded.
// - Strobes are mutually exclusive: at most one of InA/InB/Out/Clear is high in any cycle.
// CONFIGURATION
// - AU8_CHAIN_EN defined
//   - In SHOW, enter_p with Chain=1 goes to LOAD_A, with X <= Rout instead of SW.
//   - After LOAD_A, the FSM continues to WAIT_B as normal (running accumulation).
//   - enter_p with Chain=0 behaves as in the base FSM.
// - AU8_CHAIN_EN undefined: Chain and Rout are ignored; SHOW always returns to WAIT_A.
// TESTING (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2)
// - Reset mid-LOAD_B with InB high: outputs zero immediately, without waiting for a CLK edge; Phase=0 after CLR release.
// - SW=8'h25, Enter bounce 1-0-1 in 3 cycles, then held: exactly one enter_p; InA pulses once with X=8'h25 stable from 1 cycle before to 1 cycle after.
// - SW=8'h10, AS_SW=1, enter_p in WAIT_B at cycle t: InB high at t+2 only; Out high at t+7 only; Add_Subtract=1 from t+1 through SHOW.
// - Enter pressed during EXEC: no extra strobes; FSM still reaches SHOW; next press in SHOW returns to Phase=0.
// - ClearReq and Enter debounced edges in the same cycle in WAIT_B: Clear pulses for 1 cycle, InB never asserts, Phase=0.
// - AU8_CHAIN_EN, Rout=8'h3C, Chain=1, Enter in SHOW: InA pulses with X=8'h3C, Phase goes to 2; same stimulus without the macro: Phase=0, no InA.

Source files
------------

// File: rtl/au8_op_sequencer_if.sv
// Board-side and AU8-side signals of the operand sequencer.
// The master modport is the sequencer; the slave modport is the board/AU8 side.
interface au8_op_sequencer_if;
  logic [7:0] sw;
  logic       as_sw;
  logic       enter;
  logic       clear_req;
  logic       chain;
  logic [7:0] rout;
  logic [7:0] x;
  logic       in_a;
  logic       in_b;
  logic       out;
  logic       clear;
  logic       add_subtract;
  logic       busy;
  logic [2:0] phase;

  modport master (
    input  sw, as_sw, enter, clear_req, chain, rout,
    output x, in_a, in_b, out, clear, add_subtract, busy, phase
  );

  modport slave (
    output sw, as_sw, enter, clear_req, chain, rout,
    input  x, in_a, in_b, out, clear, add_subtract, busy, phase
  );
endinterface

// File: rtl/au8_op_sequencer.sv
// AU8 front-end: debounces Enter/ClearReq and sequences the A, B and result strobes.
// Define AU8_CHAIN_EN to let Enter+Chain in SHOW reload A from Rout.
module au8_op_sequencer #(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(50000),
  parameter logic [3:0]       SETTLE_CYCLES   = 4'd4
) (
  input logic                clk,
  input logic                clr,
  au8_op_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] DbLast     = DEBOUNCE_CYCLES - CNT_W'(1);
  localparam logic [3:0]       SettleLast = SETTLE_CYCLES - 4'd1;

  typedef enum logic [2:0] {
    StWaitA = 3'd0,
    StLoadA = 3'd1,
    StWaitB = 3'd2,
    StLoadB = 3'd3,
    StExec  = 3'd4,
    StLatch = 3'd5,
    StShow  = 3'd6
  } state_e;

  // Bit 0 is Enter, bit 1 is ClearReq.
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q, level_q, pulse_q;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic             enter_p, clear_p;

  assign raw     = {bus.clear_req, bus.enter};
  assign enter_p = pulse_q[0];
  assign clear_p = pulse_q[1];

  // Any sample that disagrees with the accepted level is counted; agreement restarts the count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        pulse_q[i] <= 1'b0;
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_cnt_q[i] <= '0;
          level_q[i]  <= sync2_q[i];
          pulse_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [7:0] x_q, x_d;
  logic       as_q, as_d;
  logic       in_a_q, in_a_d, in_b_q, in_b_d, out_q, out_d, clear_q, clear_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StWaitA;
      step_q  <= '0;
      x_q     <= '0;
      as_q    <= 1'b0;
      in_a_q  <= 1'b0;
      in_b_q  <= 1'b0;
      out_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      as_q    <= as_d;
      in_a_q  <= in_a_d;
      in_b_q  <= in_b_d;
      out_q   <= out_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    as_d    = as_q;
    clear_d = 1'b0;
    if (clear_p) begin
      state_d = StWaitA;
      step_d  = '0;
      x_d     = '0;
      as_d    = 1'b0;
      clear_d = 1'b1;
    end else begin
      unique case (state_q)
        StWaitA: begin
          if (enter_p) begin
            state_d = StLoadA;
            step_d  = '0;
            x_d     = bus.sw;
          end
        end
        StLoadA: begin
          if (step_q == 4'd2) begin
            state_d = StWaitB;
            step_d  = '0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        StWaitB: begin
          if (enter_p) begin
            state_d = StLoadB;
            step_d  = '0;
            x_d     = bus.sw;
            as_d    = bus.as_sw;
          end
        end
        StLoadB: begin
          if (step_q == 4'd2) begin
            state_d = StExec;
            step_d  = '0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        StExec: begin
          if (step_q == SettleLast) begin
            state_d = StLatch;
            step_d  = '0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        StLatch: begin
          if (step_q == 4'd2) begin
            state_d = StShow;
            step_d  = '0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        StShow: begin
          if (enter_p) begin
`ifdef AU8_CHAIN_EN
            if (bus.chain) begin
              state_d = StLoadA;
              step_d  = '0;
              x_d     = bus.rout;
            end else begin
              state_d = StWaitA;
            end
`else
            state_d = StWaitA;
`endif
          end
        end
        default: begin
          state_d = StWaitA;
          step_d  = '0;
        end
      endcase
    end
    // Strobes are registered from the next state so a clear in the same cycle keeps them low.
    in_a_d = (state_d == StLoadA) && (step_d == 4'd1);
    in_b_d = (state_d == StLoadB) && (step_d == 4'd1);
    out_d  = (state_d == StLatch) && (step_d == 4'd1);
  end

`ifndef AU8_CHAIN_EN
  logic unused_chain;
  assign unused_chain = ^{bus.chain, bus.rout};
`endif

  assign bus.x            = x_q;
  assign bus.in_a         = in_a_q;
  assign bus.in_b         = in_b_q;
  assign bus.out          = out_q;
  assign bus.clear        = clear_q;
  assign bus.add_subtract = as_q;
  assign bus.phase        = state_q;
  assign bus.busy         = (state_q == StLoadA) || (state_q == StLoadB) ||
                            (state_q == StExec)  || (state_q == StLatch);

endmodule

// File: tb/tb_au8_op_sequencer.sv
// Directed + randomized bench for au8_op_sequencer (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2).
// A second instance with a long EXEC window exercises presses that land while busy.
module tb_au8_op_sequencer;
  localparam int unsigned DB = 4;
  localparam int unsigned ST = 2;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  au8_op_sequencer_if bus ();
  au8_op_sequencer_if bus2 ();

  au8_op_sequencer #(.CNT_W(16), .DEBOUNCE_CYCLES(16'd4), .SETTLE_CYCLES(4'd2)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  au8_op_sequencer #(.CNT_W(16), .DEBOUNCE_CYCLES(16'd4), .SETTLE_CYCLES(4'd15)) dut2 (
    .clk(clk),
    .clr(clr),
    .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what X and Add_Subtract must currently hold.
  logic [7:0] mdl_x;
  logic       mdl_as;

  // Short output history of the main instance for the strobe-window stability rule.
  logic [7:0] hx0, hx1, hx2;
  logic       ha0, ha1, ha2, hs0, hs1;
  int         hv;
  bit         mon_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hx2 = hx1; hx1 = hx0; hx0 = bus.x;
    ha2 = ha1; ha1 = ha0; ha0 = bus.add_subtract;
    hs1 = hs0; hs0 = bus.in_a | bus.in_b | bus.out;
    if (hv < 3) hv++;
    if (mon_en) begin
      chk("onehot", 32'($countones({bus.in_a, bus.in_b, bus.out, bus.clear}) <= 1), 1);
      if (hs1 && hv == 3)
        chk("x_as_stable", 32'(hx2 == hx1 && hx1 == hx0 && ha2 == ha1 && ha1 == ha0), 1);
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int limit, input string tag);
    int n = 0;
    while (bus.phase !== ph && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.phase), 32'(ph));
  endtask

  task automatic load_a(input logic [7:0] val, input bit bounce);
    bus.sw = val;
    bus.enter = 1'b1;
    if (bounce) begin
      tick(); bus.enter = 1'b0;
      tick(); bus.enter = 1'b1;
    end
    wait_phase(3'd1, 20, "a_enter");
    mdl_x = val;
    bus.sw = 8'($urandom);
    chk("a_step0", {bus.x, bus.in_a, bus.busy}, {val, 1'b0, 1'b1});
    tick(); chk("a_ina", {bus.x, bus.in_a, bus.phase}, {val, 1'b1, 3'd1});
    tick(); chk("a_step2", {bus.x, bus.in_a, bus.phase}, {val, 1'b0, 3'd1});
    tick(); chk("a_wait_b", {bus.x, bus.in_a, bus.busy, bus.phase}, {val, 1'b0, 1'b0, 3'd2});
    bus.enter = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) begin
      tick();
      chk("a_idle", {bus.phase, bus.in_a, bus.x}, {3'd2, 1'b0, val});
    end
  endtask

  task automatic load_b(input logic [7:0] val, input logic as);
    bus.sw = val;
    bus.as_sw = as;
    bus.enter = 1'b1;
    wait_phase(3'd3, 20, "b_enter");
    mdl_x = val;
    mdl_as = as;
    bus.sw = 8'($urandom);
    bus.as_sw = ~as;
    chk("b_step0", {bus.x, bus.add_subtract, bus.in_b}, {val, as, 1'b0});
    tick(); chk("b_inb", {bus.x, bus.add_subtract, bus.in_b}, {val, as, 1'b1});
    tick(); chk("b_step2", {bus.in_b, bus.phase}, {1'b0, 3'd3});
    for (int i = 0; i < int'(ST); i++) begin
      tick();
      chk("b_exec", {bus.phase, bus.in_a, bus.in_b, bus.out, bus.add_subtract, bus.x},
          {3'd4, 3'b000, as, val});
    end
    tick(); chk("b_latch0", {bus.phase, bus.out}, {3'd5, 1'b0});
    tick(); chk("b_out", {bus.phase, bus.out, bus.x, bus.add_subtract}, {3'd5, 1'b1, val, as});
    tick(); chk("b_latch2", {bus.phase, bus.out}, {3'd5, 1'b0});
    tick(); chk("b_show", {bus.phase, bus.busy, bus.add_subtract, bus.x}, {3'd6, 1'b0, as, val});
    bus.enter = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) begin
      tick();
      chk("b_hold", {bus.phase, bus.add_subtract, bus.x}, {3'd6, as, val});
    end
  endtask

  task automatic return_wait_a();
    bus.chain = 1'b0;
    bus.enter = 1'b1;
    wait_phase(3'd0, 20, "r_enter");
    chk("r_held", {bus.x, bus.add_subtract, bus.busy}, {mdl_x, mdl_as, 1'b0});
    bus.enter = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    chk("r_idle", 32'(bus.phase), 0);
  endtask

  initial begin
    logic [7:0] a, b;
    logic       as;
    int         n, cnt_a, cnt_b, cnt_o;

    clr = 1'b0;
    mon_en = 1'b0;
    hv = 0;
    {hx0, hx1, hx2, ha0, ha1, ha2, hs0, hs1} = '0;
    {bus.sw, bus.as_sw, bus.enter, bus.clear_req, bus.chain, bus.rout} = '0;
    {bus2.sw, bus2.as_sw, bus2.enter, bus2.clear_req, bus2.chain, bus2.rout} = '0;
    mdl_x = '0;
    mdl_as = 1'b0;

    tick(); tick();
    chk("reset", {bus.x, bus.in_a, bus.in_b, bus.out, bus.clear, bus.add_subtract, bus.busy,
                  bus.phase}, 0);
    clr = 1'b1;
    hv = 0;
    mon_en = 1'b1;
    tick();
    chk("reset_rel", {bus.phase, bus.busy}, 0);

    // Bounced press loads 8'h25 once, then a subtract with 8'h10.
    load_a(8'h25, 1'b1);
    load_b(8'h10, 1'b1);
    return_wait_a();

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      as = 1'($urandom);
      load_a(a, 1'($urandom));
      load_b(b, as);
      return_wait_a();
    end

    // Simultaneous Clear and Enter edges in WAIT_B: clear wins.
    load_a(8'h81, 1'b0);
    load_b(8'h42, 1'b1);
    return_wait_a();
    load_a(8'($urandom) | 8'h01, 1'b0);
    chk("c_pre", {bus.phase, bus.add_subtract}, {3'd2, 1'b1});
    bus.sw = 8'h77;
    bus.as_sw = 1'b1;
    bus.enter = 1'b1;
    bus.clear_req = 1'b1;
    n = 0;
    cnt_b = 0;
    while (bus.clear !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (bus.in_b) cnt_b++;
    end
    chk("c_clear", 32'(bus.clear), 1);
    chk("c_state", {bus.phase, bus.x, bus.add_subtract, bus.in_b}, 0);
    mdl_x = '0;
    mdl_as = 1'b0;
    tick();
    chk("c_clear_once", 32'(bus.clear), 0);
    for (int i = 0; i < int'(DB) + 4; i++) begin
      tick();
      if (bus.in_b) cnt_b++;
      chk("c_stay", {bus.phase, bus.x}, 0);
    end
    chk("c_no_inb", 32'(cnt_b), 0);
    bus.enter = 1'b0;
    bus.clear_req = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) tick();

    // Enter with Chain=1 in SHOW.
    load_a(8'($urandom), 1'b0);
    b = 8'($urandom);
    load_b(b, 1'b0);
    bus.rout = 8'h3C;
    bus.chain = 1'b1;
    bus.sw = 8'hC3;
    bus.enter = 1'b1;
`ifdef AU8_CHAIN_EN
    wait_phase(3'd1, 20, "ch_load");
    chk("ch_x0", {bus.x, bus.in_a}, {8'h3C, 1'b0});
    tick(); chk("ch_ina", {bus.x, bus.in_a}, {8'h3C, 1'b1});
    tick(); tick();
    chk("ch_wait_b", {bus.phase, bus.x, bus.in_a}, {3'd2, 8'h3C, 1'b0});
    mdl_x = 8'h3C;
    bus.enter = 1'b0;
    bus.chain = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    load_b(8'($urandom), 1'b0);
    return_wait_a();
`else
    wait_phase(3'd0, 20, "ch_wait_a");
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.in_a) cnt_a++;
    end
    chk("ch_no_ina", 32'(cnt_a), 0);
    chk("ch_idle", {bus.phase, bus.x}, {3'd0, b});
    bus.enter = 1'b0;
    bus.chain = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
`endif

    // Second instance: a fresh press lands inside its long EXEC window and is dropped.
    bus2.sw = 8'h5A;
    bus2.enter = 1'b1;
    n = 0;
    while (bus2.phase !== 3'd2 && n < 30) begin tick(); n++; end
    chk("e_wait_b", 32'(bus2.phase), 2);
    bus2.enter = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    bus2.enter = 1'b1;
    n = 0;
    while (bus2.phase !== 3'd4 && n < 30) begin tick(); n++; end
    chk("e_exec", 32'(bus2.phase), 4);
    bus2.enter = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_o = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt_a += int'(bus2.in_a); cnt_b += int'(bus2.in_b); cnt_o += int'(bus2.out);
    end
    chk("e_repress_in_exec", 32'(bus2.phase), 4);
    bus2.enter = 1'b1;
    n = 0;
    while (bus2.phase !== 3'd6 && n < 40) begin
      tick();
      n++;
      cnt_a += int'(bus2.in_a); cnt_b += int'(bus2.in_b); cnt_o += int'(bus2.out);
    end
    chk("e_show", 32'(bus2.phase), 6);
    chk("e_no_extra", {16'(cnt_a), 16'(cnt_b)}, 0);
    chk("e_one_out", 32'(cnt_o), 1);
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    chk("e_show_hold", {bus2.phase, bus2.add_subtract}, {3'd6, 1'b0});
    bus2.enter = 1'b0;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    bus2.enter = 1'b1;
    n = 0;
    while (bus2.phase !== 3'd0 && n < 20) begin tick(); n++; end
    chk("e_back_wait_a", 32'(bus2.phase), 0);
    bus2.enter = 1'b0;

    // Asynchronous reset while InB is high.
    load_a(8'($urandom), 1'b0);
    bus.sw = 8'($urandom) | 8'h01;
    bus.as_sw = 1'b1;
    bus.enter = 1'b1;
    wait_phase(3'd3, 20, "r_load_b");
    tick();
    chk("r_inb_high", 32'(bus.in_b), 1);
    bus.enter = 1'b0;
    mon_en = 1'b0;
    clr = 1'b0;
    #1;
    chk("r_async", {bus.x, bus.in_a, bus.in_b, bus.out, bus.clear, bus.add_subtract, bus.busy,
                    bus.phase}, 0);
    tick(); tick();
    clr = 1'b1;
    hv = 0;
    mon_en = 1'b1;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    chk("r_after", {bus.phase, bus.in_b, bus.x}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
